// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-back path.
package regfile_pkg;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [63:0] reg_data_t;

  localparam reg_addr_t ZERO_REG = 5'd31;

  // Encoding of the arbiter's last_grant bit.
  localparam logic LAST_ALU = 1'b0;
  localparam logic LAST_MEM = 1'b1;

  // 'reg' is a reserved word, so the destination field is called addr.
  typedef struct packed {
    logic      valid;
    reg_addr_t addr;
    reg_data_t data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter_2.sv
// Two-request arbiter, one-hot grant (bit 0 = ALU, bit 1 = mem).
// Round-robin when WBARB_ROUND_ROBIN_EN is defined, otherwise mem has fixed priority.
module rr_arbiter_2
  import regfile_pkg::*;
(
`ifdef WBARB_ROUND_ROBIN_EN
  input  logic       clk,
  input  logic       reset,
`endif
  input  logic [1:0] req,
  output logic [1:0] grant
);

`ifdef WBARB_ROUND_ROBIN_EN
  logic last_grant;

  // Under contention the requester that did not win most recently goes next.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (last_grant == LAST_ALU) ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= LAST_ALU;
    end else if (grant != 2'b00) begin
      last_grant <= grant[1] ? LAST_MEM : LAST_ALU;
    end
  end
`else
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between ALU and load write-back, with a
// registered write stage and a saturating contention counter. Macro: WBARB_ROUND_ROBIN_EN.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic [1:0]        req;
  logic [1:0]        grant;
  logic              accepted;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;

  assign req = {mem_valid, alu_valid};

  rr_arbiter_2 u_arb (
`ifdef WBARB_ROUND_ROBIN_EN
    .clk   (clk),
    .reset (reset),
`endif
    .req   (req),
    .grant (grant)
  );

  assign alu_ready = grant[0] & ~reset;
  assign mem_ready = grant[1] & ~reset;
  assign accepted  = alu_ready | mem_ready;
  assign sel_reg   = grant[1] ? mem_reg  : alu_reg;
  assign sel_data  = grant[1] ? mem_data : alu_data;

  // Writes to the zero register are consumed but never reach the register file.
  always_ff @(posedge clk) begin
    if (reset) begin
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
      conflict_cnt  <= '0;
    end else begin
      RegWrite <= accepted && (sel_reg != ADDR_W'(ZERO_REG));
      if (accepted && (sel_reg != ADDR_W'(ZERO_REG))) begin
        WriteRegister <= sel_reg;
        WriteData     <= sel_data;
      end
      if (alu_valid && mem_valid && (conflict_cnt != {CNT_W{1'b1}})) begin
        conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
    end
  end

endmodule
